// File: rtl/btn_event_buffer.sv
// btn_event_buffer: synchronised, debounced button events queued in a FIFO behind an MMIO window; define BTN_IRQ_EN for irq
module btn_event_buffer #(
   parameter int NUM_BTN         = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 8,
   parameter bit ACTIVE_LOW      = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn,
   input  logic               bus_sel,
   input  logic               bus_we,
   input  logic [3:0]         bus_addr,
   input  logic [31:0]        bus_wdata,
   output logic [31:0]        bus_rdata
`ifdef BTN_IRQ_EN
   ,
   output logic               irq
`endif
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BTN-1:0] IDLE = {NUM_BTN{ACTIVE_LOW}};
   logic [NUM_BTN-1:0] s1, s2, pressed, stable, tog, pending, pedge, grant;
   logic [CW-1:0]      cnt [NUM_BTN];
   logic [8:0]         mem [FIFO_DEPTH];
   logic [8:0]         head;
   logic [AW-1:0]      wptr, rptr;
   logic [AW:0]        count;
   logic [7:0]         gch;
   logic               gedge, ovf, empty, full, rd, wr, flush, clr, push, pop, acc, drop, ovf_set, irq_en;
   logic [1:0]         a;
   logic [31:0]        rsel, status, ctrl_rd;
   logic               unused;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1 <= IDLE;
         s2 <= IDLE;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   assign pressed = ACTIVE_LOW ? ~s2 : s2;
   // a channel toggles once its new level has been seen on DEBOUNCE_CYCLES consecutive edges
   always_comb begin
      tog = '0;
      for (int k = 0; k < NUM_BTN; k++)
         tog[k] = (pressed[k] != stable[k]) && (cnt[k] == CMAX);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stable <= '0;
         for (int k = 0; k < NUM_BTN; k++) cnt[k] <= '0;
      end else begin
         stable <= stable ^ tog;
         for (int k = 0; k < NUM_BTN; k++)
            cnt[k] <= (pressed[k] == stable[k] || tog[k]) ? '0 : cnt[k] + 1'b1;
      end
   always_comb begin
      grant = '0;
      gch   = '0;
      gedge = 1'b0;
      for (int k = NUM_BTN - 1; k >= 0; k--)
         if (pending[k]) begin
            grant    = '0;
            grant[k] = 1'b1;
            gch      = 8'(k);
            gedge    = pedge[k];
         end
   end
   assign a       = bus_addr[3:2];
   assign rd      = bus_sel & ~bus_we;
   assign wr      = bus_sel & bus_we;
   assign flush   = wr && a == 2'd3 && bus_wdata[0];
   assign clr     = wr && a == 2'd3 && bus_wdata[1];
   assign empty   = count == '0;
   assign full    = count == (AW+1)'(FIFO_DEPTH);
   assign pop     = rd && a == 2'd1 && !empty;
   assign push    = |pending & ~flush;
   assign acc     = push & (~full | pop);
   assign drop    = push & full & ~pop;
   assign ovf_set = ~flush & (drop | (|(tog & pending & ~grant)));
   assign head    = mem[rptr];
   assign status  = {13'b0, full, empty, ovf, 16'(count)};
   assign ctrl_rd = {29'b0, irq_en, 2'b00};
   assign rsel    = a == 2'd0 ? 32'(stable) :
                    a == 2'd1 ? (empty ? 32'b0 : {1'b1, 22'b0, head}) :
                    a == 2'd2 ? status : ctrl_rd;
   always_ff @(posedge clk)
      if (acc) mem[wptr] <= {gedge, gch};
   // a toggle lands in pending even while the previous one is being pushed; only a genuine overwrite is overflow
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pending   <= '0;
         pedge     <= '0;
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         bus_rdata <= '0;
      end else begin
         pending <= flush ? '0 : (pending & ~grant) | tog;
         pedge   <= (pedge & ~tog) | (tog & ~stable);
         wptr    <= flush ? '0 : wptr + AW'(acc);
         rptr    <= flush ? '0 : rptr + AW'(pop);
         count   <= flush ? '0 : count + (AW+1)'(acc) - (AW+1)'(pop);
         ovf     <= ovf_set | (ovf & ~clr);
         if (rd) bus_rdata <= rsel;
      end
`ifdef BTN_IRQ_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr && a == 2'd3) irq_en <= bus_wdata[2];
         irq <= irq_en & (~empty | ovf);
      end
   assign unused = ^{bus_addr[1:0], bus_wdata[31:3]};
`else
   assign irq_en = 1'b0;
   assign unused = ^{bus_addr[1:0], bus_wdata[31:2]};
`endif
endmodule

// File: tb/tb_btn_event_buffer.sv
// tb_btn_event_buffer: directed, table-driven and randomized checks of btn_event_buffer against a queue-based model
module tb_btn_event_buffer;
   localparam int N = 2;
   localparam int D = 4;
   localparam int DEPTH = 8;
`ifdef BTN_IRQ_EN
   localparam logic [31:0] CTRL_RB = 32'h4;
`else
   localparam logic [31:0] CTRL_RB = 32'h0;
`endif
   logic clk, rst_n, bus_sel, bus_we;
   logic [N-1:0] btn;
   logic [3:0] bus_addr;
   logic [31:0] bus_wdata, bus_rdata, d;
   int ncmp, nbad;
`ifdef BTN_IRQ_EN
   logic irq;
`endif
   btn_event_buffer #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .bus_sel(bus_sel), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
`ifdef BTN_IRQ_EN
      , .irq(irq)
`endif
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
   logic [N-1:0] mp1, mp2, mst, mpend, medge;
   int run [N];
   logic [8:0] mq [$];
   logic movf, mien;
   logic [31:0] mrd;
   task automatic model_reset();
      mp1 = '1; mp2 = '1; mst = '0; mpend = '0; medge = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
      mq.delete(); movf = 0; mien = 0; mrd = 0;
   endtask
   task automatic model_step();
      logic [N-1:0] pr, tg;
      logic r, w, fl, cl, pp;
      logic [1:0] ad;
      int g, sz;
      pr = ~mp2;
      tg = '0;
      for (int i = 0; i < N; i++)
         if (pr[i] != mst[i]) begin
            run[i]++;
            if (run[i] == D) begin tg[i] = 1; run[i] = 0; end
         end else run[i] = 0;
      r = bus_sel & ~bus_we; w = bus_sel & bus_we; ad = bus_addr[3:2];
      fl = w && ad == 3 && bus_wdata[0];
      cl = w && ad == 3 && bus_wdata[1];
      sz = mq.size();
      pp = r && ad == 1 && sz > 0;
      if (r)
         case (ad)
            2'd0: mrd = 32'(mst);
            2'd1: mrd = sz > 0 ? {1'b1, 22'b0, mq[0]} : 32'h0;
            2'd2: mrd = {13'b0, sz == DEPTH, sz == 0, movf, 16'(sz)};
            default: mrd = {29'b0, mien, 2'b00};
         endcase
      if (cl) movf = 0;
      g = -1;
      for (int i = N - 1; i >= 0; i--) if (mpend[i]) g = i;
      if (pp) void'(mq.pop_front());
      if (fl) begin
         mq.delete();
         mpend = '0;
      end else begin
         if (g >= 0) begin
            if (sz < DEPTH || pp) mq.push_back({medge[g], 8'(g)});
            else movf = 1;
            mpend[g] = 0;
         end
         for (int i = 0; i < N; i++)
            if (tg[i]) begin
               if (mpend[i]) movf = 1;
               mpend[i] = 1;
               medge[i] = ~mst[i];
            end
      end
`ifdef BTN_IRQ_EN
      if (w && ad == 3) mien = bus_wdata[2];
`endif
      mst = mst ^ tg;
      mp2 = mp1;
      mp1 = btn;
   endtask
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic bus_read(input logic [1:0] ad, output logic [31:0] q);
      bus_sel = 1; bus_we = 0; bus_addr = {ad, 2'b00};
      tick();
      bus_sel = 0;
      q = bus_rdata;
   endtask
   task automatic bus_write(input logic [1:0] ad, input logic [31:0] wd);
      bus_sel = 1; bus_we = 1; bus_addr = {ad, 2'b00}; bus_wdata = wd;
      tick();
      bus_sel = 0; bus_we = 0; bus_wdata = 0;
   endtask
   typedef struct {
      logic       we;
      logic [1:0] ad;
      logic [31:0] v;
      string      name;
   } vec_t;
   vec_t tbl [14];
   initial begin
      ncmp = 0; nbad = 0;
      rst_n = 0; btn = '1; bus_sel = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_rdata", bus_rdata, 32'h0);
      rst_n = 1;
      model_reset();
      ticks(20);
      bus_read(2, d); check("t1_status", d, 32'h00020000);
      bus_read(0, d); check("t1_level", d, 32'h0);
      btn[0] = 0; ticks(3); btn[0] = 1; ticks(10);
      bus_read(0, d); check("t2_level", d, 32'h0);
      bus_read(2, d); check("t2_status", d, 32'h00020000);
      btn[1] = 0; ticks(5);
      bus_read(0, d); check("t3_level_early", d, 32'h0);
      bus_read(0, d); check("t3_level_on_time", d, 32'h2);
      ticks(2);
      bus_read(1, d); check("t3_event", d, 32'h80000101);
      bus_read(1, d); check("t3_event_empty", d, 32'h0);
      btn = '1; ticks(10);
      bus_write(3, 32'h1);
      btn = '0; ticks(5);
      bus_read(0, d); check("t4_level_early", d, 32'h0);
      bus_read(0, d); check("t4_level_both", d, 32'h3);
      ticks(3);
      bus_read(1, d); check("t4_event_ch0", d, 32'h80000100);
      bus_read(1, d); check("t4_event_ch1", d, 32'h80000101);
      bus_read(1, d); check("t4_event_empty", d, 32'h0);
      btn = '1; ticks(10);
      bus_write(3, 32'h1);
      for (int p = 0; p < 10; p++) begin
         btn[0] = 0; ticks(8);
         btn[0] = 1; ticks(8);
      end
      ticks(10);
      tbl[0]  = '{0, 2'd2, 32'h00050008, "t5_full_ovf"};
      tbl[1]  = '{1, 2'd3, 32'h00000002, "t5_clr_ovf"};
      tbl[2]  = '{0, 2'd2, 32'h00040008, "t5_ovf_cleared"};
      tbl[3]  = '{0, 2'd1, 32'h80000100, "t5_first_event"};
      tbl[4]  = '{0, 2'd2, 32'h00000007, "t5_after_pop"};
      tbl[5]  = '{1, 2'd3, 32'h00000004, "t5_irq_en"};
      tbl[6]  = '{0, 2'd3, CTRL_RB,      "t5_ctrl_rb"};
      tbl[7]  = '{1, 2'd0, 32'hffffffff, "t5_wr_level"};
      tbl[8]  = '{0, 2'd0, 32'h00000000, "t5_level_ro"};
      tbl[9]  = '{1, 2'd2, 32'hffffffff, "t5_wr_status"};
      tbl[10] = '{0, 2'd1, 32'h80000000, "t5_release_event"};
      tbl[11] = '{0, 2'd2, 32'h00000006, "t5_status_ro"};
      tbl[12] = '{1, 2'd3, 32'h00000001, "t5_flush"};
      tbl[13] = '{0, 2'd2, 32'h00020000, "t5_flushed"};
      for (int i = 0; i < 14; i++)
         if (tbl[i].we) bus_write(tbl[i].ad, tbl[i].v);
         else begin
            bus_read(tbl[i].ad, d);
            check(tbl[i].name, d, tbl[i].v);
         end
      bus_read(2, d); check("t6_pre_status", d, 32'h00020000);
      btn[0] = 0; ticks(3);
      rst_n = 0;
      #1 check("t6_rdata_async_clear", bus_rdata, 32'h0);
      model_reset();
      @(posedge clk); @(negedge clk);
      check("t6_rdata_in_reset", bus_rdata, 32'h0);
      rst_n = 1;
      model_reset();
      ticks(5);
      bus_read(0, d); check("t6_level_early", d, 32'h0);
      bus_read(0, d); check("t6_level_redetect", d, 32'h1);
      ticks(2);
      bus_read(1, d); check("t6_event", d, 32'h80000100);
      bus_read(1, d); check("t6_event_empty", d, 32'h0);
      btn = '1; ticks(10);
      bus_write(3, 32'h3);
      for (int c = 0; c < 3000; c++) begin
         int r;
         for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
         r = $urandom_range(0, 99);
         bus_sel = 0; bus_we = 0;
         if (r < 35) begin
            bus_sel = 1; bus_addr = 4'($urandom_range(0, 15));
         end else if (r < 38) begin
            bus_sel = 1; bus_we = 1; bus_addr = 4'hc;
            bus_wdata = r == 35 ? 32'h2 : r == 36 ? 32'h1 : 32'($urandom_range(0, 7));
         end else if (r == 38) begin
            bus_sel = 1; bus_we = 1; bus_addr = 4'($urandom_range(0, 11)); bus_wdata = $urandom;
         end
         tick();
         if (r < 35) check("rand_read", bus_rdata, mrd);
      end
      bus_sel = 0; bus_we = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
